// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared constants and types for the multi-ported register file
package regfile_mp_pkg;

  localparam int RV_DATA_WIDTH     = 32;
  localparam int RV_REG_ADDR_WIDTH = 5;
  localparam int ZERO_REG_IDX      = 0;

  // Which source drives a read port this cycle.
  typedef enum logic [1:0] {
    SRC_OFF,
    SRC_ZERO,
    SRC_FWD,
    SRC_ARRAY
  } rd_src_e;

endpackage

// File: rtl/regfile_fwd_mux.sv
// rtl/regfile_fwd_mux.sv - per-read-port priority bypass over write ports and stored array value
module regfile_fwd_mux
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = RV_DATA_WIDTH,
  parameter int ADDR_WIDTH = RV_REG_ADDR_WIDTH,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int FORWARD    = 1
) (
  input  logic                         enable,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        array_data,
  input  logic                         array_busy,
  input  logic [NUM_WR-1:0]            write_enable,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0]        data,
  output logic                         busy
);

  rd_src_e               src;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Ascending scan: a later (higher-index) match overrides, so the highest port wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if ((FORWARD != 0) && write_enable[j] &&
          (write_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    src = SRC_ARRAY;
    if (!enable) begin
      src = SRC_OFF;
    end else if ((ZERO_REG != 0) && (addr == ADDR_WIDTH'(ZERO_REG_IDX))) begin
      src = SRC_ZERO;
    end else if (fwd_hit) begin
      src = SRC_FWD;
    end
  end

  always_comb begin
    data = '0;
    busy = 1'b0;
    case (src)
      SRC_FWD: begin
        data = fwd_data;
        busy = 1'b0;
      end
      SRC_ARRAY: begin
        data = array_data;
        busy = array_busy;
      end
      default: begin
        data = '0;
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-ported register file with write forwarding and pending-write scoreboard
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = RV_DATA_WIDTH,
  parameter int ADDR_WIDTH = RV_REG_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int FORWARD    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            read_enable,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            write_enable,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] write_data,
  input  logic                         rsv_valid,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy;

  function automatic logic is_dropped(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_WIDTH'(ZERO_REG_IDX));
  endfunction

  // Later assignments win: higher write ports override lower ones, reserve overrides write-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (write_enable[j] && !is_dropped(write_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
          mem[write_addr[j*ADDR_WIDTH +: ADDR_WIDTH]]  <= write_data[j*DATA_WIDTH +: DATA_WIDTH];
          busy[write_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
        end
      end
      if (rsv_valid && !is_dropped(rsv_addr)) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_fwd_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WR     (NUM_WR),
      .ZERO_REG   (ZERO_REG),
      .FORWARD    (FORWARD)
    ) u_fwd_mux (
      .enable       (read_enable[k]),
      .addr         (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .array_data   (mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]),
      .array_busy   (busy[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .data         (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy         (rd_busy[k])
    );
  end

endmodule
